// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction fetch stage.
// Issues sequential instruction-memory requests from the fetch PC. At most two
// requests or buffered instructions are outstanding at any time, tracked by a
// credit count. An epoch bit tags each request, so a redirect from EXE can
// drop wrong-path responses that are still in flight. Accepted instructions
// are held in a 2-entry buffer that DEC drains.
// Optional feature: define FETCH_STATS_EN to add the stat_fetched and
// stat_flushed counter ports.
// -----------------------------------------------------------------------------
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-memory request channel
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  // instruction-memory response channel (in order, latency >= 1)
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // redirect from EXE
  input  logic        br_taken,
  input  logic [31:0] br_target,
  // towards DEC
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        dec_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  // fetch PC and redirect epoch
  logic [31:0] r_fpc;
  logic        r_epoch;

  // in-flight queue: {pc, epoch} for each accepted request, oldest first
  logic [31:0] r_ifq_pc [2];
  logic        r_ifq_ep [2];
  logic        r_ifq_rd;
  logic        r_ifq_wr;
  logic [1:0]  r_ifq_cnt;

  // output buffer: {pc, instruction} waiting for DEC, oldest first
  logic [31:0] r_obq_pc   [2];
  logic [31:0] r_obq_data [2];
  logic        r_obq_rd;
  logic        r_obq_wr;
  logic [1:0]  r_obq_cnt;

  logic [2:0]  w_credit;
  logic        w_req_fire;
  logic        w_rsp_fire;
  logic        w_rsp_keep;
  logic        w_pop;
  logic [31:0] w_br_pc;

  // Credit covers every request still in flight (wrong-path ones included)
  // plus every buffered instruction. Capping it at two guarantees that a
  // returning response always finds a free output-buffer slot.
  assign w_credit = {1'b0, r_ifq_cnt} + {1'b0, r_obq_cnt};

  // The target is word aligned, so the two low bits are dropped.
  assign w_br_pc = br_target & 32'hFFFF_FFFC;

  // No request is issued during reset or in a redirect cycle.
  assign imem_req_valid = !rst && !br_taken && (w_credit < 3'd2);
  assign imem_req_addr  = r_fpc;

  assign w_req_fire = imem_req_valid & imem_req_ready;
  // A response that arrives with nothing in flight (e.g. after reset) is ignored.
  assign w_rsp_fire = imem_rsp_valid & (r_ifq_cnt != 2'd0);
  // A redirect in the same cycle wins: the response is dropped even on a matching epoch.
  assign w_rsp_keep = w_rsp_fire & (r_ifq_ep[r_ifq_rd] == r_epoch) & !br_taken;
  // A redirect flushes the buffer, so a same-cycle DEC pop is superseded.
  assign w_pop      = valid_out & dec_ready & !br_taken;

  // Drive the DEC outputs from the buffer head, or all zero when it is empty.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
    valid_out   = 1'b0;
    instruction = 32'h0;
    pc_out      = 32'h0;
    if (!rst && (r_obq_cnt != 2'd0)) begin
      valid_out   = 1'b1;
      instruction = r_obq_data[r_obq_rd];
      pc_out      = r_obq_pc[r_obq_rd];
    end
  end

  // Advance the fetch PC and the epoch: a redirect loads the target, an accepted request steps by 4.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every block sees values from before the edge.
    if (rst) begin
      r_fpc   <= RESET_PC;
      r_epoch <= 1'b0;
    end else if (br_taken) begin
      r_fpc   <= w_br_pc;
      r_epoch <= ~r_epoch;
    end else if (w_req_fire) begin
      r_fpc   <= r_fpc + 32'd4;
    end
  end

  // Update the in-flight queue pointers and occupancy: push on accept, pop on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifq_rd  <= 1'b0;
      r_ifq_wr  <= 1'b0;
      r_ifq_cnt <= 2'd0;
    end else begin
      if (w_req_fire) r_ifq_wr <= ~r_ifq_wr;
      if (w_rsp_fire) r_ifq_rd <= ~r_ifq_rd;
      r_ifq_cnt <= r_ifq_cnt + {1'b0, w_req_fire} - {1'b0, w_rsp_fire};
    end
  end

  // Store the PC and epoch of each accepted request.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays are not reset; the pointers and counts are, and the outputs are masked while empty.
    if (w_req_fire) begin
      r_ifq_pc[r_ifq_wr] <= r_fpc;
      r_ifq_ep[r_ifq_wr] <= r_epoch;
    end
  end

  // Update the output buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || br_taken) begin
      r_obq_rd  <= 1'b0;
      r_obq_wr  <= 1'b0;
      r_obq_cnt <= 2'd0;
    end else begin
      if (w_rsp_keep) r_obq_wr <= ~r_obq_wr;
      if (w_pop)      r_obq_rd <= ~r_obq_rd;
      r_obq_cnt <= r_obq_cnt + {1'b0, w_rsp_keep} - {1'b0, w_pop};
    end
  end

  // Store each current-epoch response with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (w_rsp_keep) begin
      r_obq_pc[r_obq_wr]   <= r_ifq_pc[r_ifq_rd];
      r_obq_data[r_obq_wr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;

  // Count instructions handed to DEC and redirect cycles; both wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fetched <= 32'd0;
      r_stat_flushed <= 32'd0;
    end else begin
      if (w_pop)    r_stat_fetched <= r_stat_fetched + 32'd1;
      if (br_taken) r_stat_flushed <= r_stat_flushed + 32'd1;
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch -- self-checking bench for fetch.
// Main path: a table of per-cycle vectors with hand-computed expectations.
// Redirect, back-pressure and reset corners are hand-written sequences.
// A second instance with RESET_PC = FFFF_FFF8 shares all inputs and is used
// to observe address wrap. Counter checks are included when FETCH_STATS_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        dec_ready;

  logic        hi_req_valid;
  logic [31:0] hi_req_addr;
  logic [31:0] hi_instruction;
  logic [31:0] hi_pc_out;
  logic        hi_valid_out;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
  logic [31:0] hi_stat_fetched;
  logic [31:0] hi_stat_flushed;
`endif

  always #5 clk = ~clk;

  fetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .dec_ready      (dec_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (hi_req_valid),
    .imem_req_addr  (hi_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .instruction    (hi_instruction),
    .pc_out         (hi_pc_out),
    .valid_out      (hi_valid_out),
    .dec_ready      (dec_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (hi_stat_fetched),
    .stat_flushed   (hi_stat_flushed)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic [31:0] mem_q [$];   // addresses accepted by memory, not yet answered
  logic [31:0] hi_q  [$];   // addresses accepted from the high-reset instance
  logic        s_req_valid;
  logic [31:0] s_req_addr;

  typedef struct {
    logic        dr;
    logic        rsp_en;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_vo;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [9];

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample the request
  // 1 time unit later, then model a 1-cycle in-order memory at the rising edge.
  task automatic tick(input logic br, input logic [31:0] tgt, input logic dr, input logic rsp_en);
    br_taken       = br;
    br_target      = tgt;
    dec_ready      = dr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (rsp_en && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0]);
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    if (hi_req_valid && imem_req_ready) hi_q.push_back(hi_req_addr);
    @(posedge clk);
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (s_req_valid && imem_req_ready) begin
      mem_q.push_back(s_req_addr);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic check_dec(input string name, input logic exp_vo, input logic [31:0] exp_pc);
    check({name, "_valid"}, {31'b0, valid_out}, {31'b0, exp_vo});
    check({name, "_pc"}, pc_out, exp_pc);
    check({name, "_instr"}, instruction, exp_vo ? mem_word(exp_pc) : 32'h0);
  endtask

  // Reset for one cycle and check the outputs while reset is held.
  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    br_taken = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_dec("rst", 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    mem_q.delete();
    hi_q.delete();
  endtask

  // Run cycles until valid_out rises, bounded by a cycle budget.
  task automatic wait_valid(input string name, input int max_cycles);
    for (int k = 0; k < max_cycles && !valid_out; k++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    check({name, "_timeout"}, {31'b0, valid_out}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    br_taken = 1'b0;
    br_target = 32'h0;
    dec_ready = 1'b0;

    // Streaming with a 1-cycle memory and DEC always ready:
    //          dr    rsp   rv    addr    vo    pc
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd8,  1'b1, 32'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b0, 32'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'd24, 1'b1, 32'd16};

    @(negedge clk);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();

    // Table-driven stream from reset.
    for (int i = 0; i < 9; i++) begin
      check_dec($sformatf("seq%0d", i), vecs[i].exp_vo, vecs[i].exp_pc);
      tick(1'b0, 32'h0, vecs[i].dr, vecs[i].rsp_en);
      check($sformatf("seq%0d_req_valid", i), {31'b0, s_req_valid}, {31'b0, vecs[i].exp_rv});
      check($sformatf("seq%0d_req_addr", i), s_req_addr, vecs[i].exp_addr);
    end

    // The high-reset instance wraps from FFFF_FFFC to 0.
    check("wrap_count", hi_q.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
    if (hi_q.size() >= 3) begin
      check("wrap_addr0", hi_q[0], 32'hFFFF_FFF8);
      check("wrap_addr1", hi_q[1], 32'hFFFF_FFFC);
      check("wrap_addr2", hi_q[2], 32'h0000_0000);
    end

    // Two redirects with DEC stalled: no request in either cycle.
    tick(1'b1, 32'h40, 1'b0, 1'b1);
    check("redir1_req_valid", {31'b0, s_req_valid}, 32'h0);
    tick(1'b1, 32'h80, 1'b0, 1'b1);
    check("redir2_req_valid", {31'b0, s_req_valid}, 32'h0);
    check_dec("redir_flushed", 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check("redir_next_addr", s_req_addr, 32'h80);
`ifdef FETCH_STATS_EN
    check("stat_fetched", stat_fetched, 32'd5);
    check("stat_flushed", stat_flushed, 32'd2);
`endif

    // DEC stalled for 10 cycles: two requests, buffer holds pc 0 and 4.
    do_reset();
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_accepts", n_acc - acc0, 32'd2);
    check("stall_req_valid", {31'b0, s_req_valid}, 32'h0);
    check_dec("stall_head", 1'b1, 32'h0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    check("stall_pop_req_valid", {31'b0, s_req_valid}, 32'h0);
    check_dec("stall_second", 1'b1, 32'h4);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_resume_valid", {31'b0, s_req_valid}, 32'h1);
    check("stall_resume_addr", s_req_addr, 32'h8);

    // Reset mid-operation with a request in flight; its late response must be ignored.
    rst = 1'b1;
    #1;
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_dec("midrst", 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    check("midrst_stale_rsp_sent", mem_q.size(), 32'd0);
    check("midrst_hold_valid", {31'b0, s_req_valid}, 32'h1);
    check("midrst_hold_addr0", s_req_addr, 32'h0);
    check_dec("midrst_stale", 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    check("midrst_hold_addr1", s_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    wait_valid("midrst_first", 10);
    check_dec("midrst_first", 1'b1, 32'h0);

    // Redirect to 0x100 with two requests in flight: both responses dropped.
    do_reset();
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    check("br2_inflight", mem_q.size(), 32'd2);
    tick(1'b1, 32'h100, 1'b1, 1'b0);
    check("br2_req_valid", {31'b0, s_req_valid}, 32'h0);
    wait_valid("br2_first", 12);
    check_dec("br2_first", 1'b1, 32'h100);

    // Redirect straight after reset with free credit, then a redirect
    // colliding with a response and a DEC pop.
    do_reset();
    tick(1'b1, 32'h203, 1'b0, 1'b1);
    check("br0_req_valid", {31'b0, s_req_valid}, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check("br0_next_valid", {31'b0, s_req_valid}, 32'h1);
    check("br0_next_addr", s_req_addr, 32'h200);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check_dec("brc_before", 1'b1, 32'h200);
    tick(1'b1, 32'h300, 1'b1, 1'b1);
    check("brc_rsp_driven", {31'b0, imem_rsp_valid}, 32'h1);
    check("brc_req_valid", {31'b0, s_req_valid}, 32'h0);
    check_dec("brc_after", 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check("brc_next_addr", s_req_addr, 32'h300);

    // Counters return to zero on reset.
    do_reset();
`ifdef FETCH_STATS_EN
    check("stat_fetched_rst", stat_fetched, 32'd0);
    check("stat_flushed_rst", stat_flushed, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
